// File: rtl/arc4_pkg.sv
// Shared types for the doublecrack front end: ciphertext RAM addressing, key width
// and the feeder control states.
package arc4_pkg;

  localparam int CT_ADDR_W = 8;
  localparam int KEY_W     = 24;

  typedef logic [CT_ADDR_W-1:0] ct_addr_t;
  typedef logic [KEY_W-1:0]     key_t;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_START,
    S_BUSY,
    S_WAIT,
    S_RES
  } feeder_state_t;

endpackage

// File: rtl/ct_ram.sv
// Ciphertext store: one write port plus an independent registered read port.
// A read and write to the same address in one cycle returns the previous contents.
module ct_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register is the only part touched by reset; array contents survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ct_feeder.sv
// Loads a length-prefixed ciphertext into ct_ram, launches doublecrack with a single
// en pulse, and holds the returned key for the host until acknowledged.
module ct_feeder
  import arc4_pkg::*;
#(
  parameter int ADDR_W = arc4_pkg::CT_ADDR_W,
  parameter int KEY_W  = arc4_pkg::KEY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              crk_en,
  input  logic              crk_rdy,
  input  logic [KEY_W-1:0]  crk_key,
  input  logic              crk_key_valid,
  input  logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_rddata,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [KEY_W-1:0]  res_key,
  output logic              res_found,
  output logic              busy
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  feeder_state_t     state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              res_valid_q, res_valid_d;
  logic              res_found_q, res_found_d;
  logic [KEY_W-1:0]  res_key_q, res_key_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;

  // Ready is held low while reset is asserted so the host never sees a phantom slot.
  assign in_ready = rst_n && ((state_q == S_LEN) || (state_q == S_DATA));
  assign busy     = (state_q != S_LEN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    res_valid_d = res_valid_q;
    res_found_d = res_found_q;
    res_key_d   = res_key_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    crk_en      = 1'b0;

    unique case (state_q)
      S_LEN: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = ADDR_W'(in_data);
          cnt_d   = CNT_ONE;
          if (in_data == 8'd0) begin
            res_valid_d = 1'b1;
            res_found_d = 1'b0;
            res_key_d   = '0;
            state_d     = S_RES;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q[ADDR_W-1:0];
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == {1'b0, len_q}) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (crk_rdy) begin
          crk_en  = 1'b1;
          state_d = S_BUSY;
        end
      end
      // rdy may linger for a cycle after en; only a sampled low proves the crack began.
      S_BUSY: begin
        if (!crk_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (crk_rdy) begin
          res_valid_d = 1'b1;
          res_found_d = crk_key_valid;
          res_key_d   = crk_key_valid ? crk_key : '0;
          state_d     = S_RES;
        end
      end
      S_RES: begin
        if (res_ack && res_valid_q) begin
          res_valid_d = 1'b0;
          state_d     = S_LEN;
        end
      end
      default: begin
        state_d = S_LEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN;
      cnt_q       <= '0;
      len_q       <= '0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      res_valid_q <= res_valid_d;
      res_found_q <= res_found_d;
      res_key_q   <= res_key_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_key   = res_key_q;

  ct_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ct_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (in_data),
    .raddr_i (ct_addr),
    .rdata_o (ct_rddata)
  );

endmodule
